// File: rtl/dma_priority_resolver.sv
// ============================================================================
//  Module      : dma_priority_resolver
//  Description : DMA channel-request arbiter with fixed/rotating priority,
//                one-hot DACK generation and software-request clear pulses.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dma_priority_resolver #(
  parameter  int NUM_CH = 4,
  localparam int CW     = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic [NUM_CH-1:0] requestReg,
  input  logic              dreqSense,
  input  logic              rotatingPriority,
  input  logic              controllerDisable,
  input  logic              HRQ,
  input  logic              HLDA,
  input  logic              assertDACK,
  input  logic              intEOP,
  output logic              requestPending,
  output logic [NUM_CH-1:0] DACK,
  output logic [CW-1:0]     grantedChannel,
  output logic              grantValid,
  output logic [NUM_CH-1:0] clearSwRequest
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_ARB   = 3'b010,
    S_GRANT = 3'b100
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [NUM_CH-1:0] w_eff;
  logic [NUM_CH-1:0] r_reqQ;
  logic [CW-1:0]     r_lowestCh;
  logic [CW-1:0]     r_grantedChannel;
  logic              r_sawDack;
  logic [NUM_CH-1:0] r_clearSw;
  logic [CW-1:0]     w_base;
  logic [CW-1:0]     w_winner;
  logic              w_latch;
  logic              w_release;

  // Software requests bypass the mask; disable overrides everything.
  assign w_eff = controllerDisable ? '0 :
                 (((DREQ ^ {NUM_CH{dreqSense}}) & ~maskReg) | requestReg);

  // Scan from the highest offset down so the nearest requester above the
  // pointer is the last (winning) assignment.
  always_comb begin
    logic [CW-1:0] w_idx;
    w_base   = rotatingPriority ? r_lowestCh : CW'(NUM_CH - 1);
    w_winner = w_base;
    w_idx    = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_idx = CW'((int'(w_base) + k) % NUM_CH);
      if (r_reqQ[w_idx]) begin
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_latch   = 1'b0;
    w_release = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (requestPending) begin
          w_next = S_ARB;
        end
      end
      S_ARB: begin
        if (r_reqQ == '0) begin
          w_next = S_IDLE;
        end else if (HRQ && HLDA) begin
          w_next  = S_GRANT;
          w_latch = 1'b1;
        end else if (!HRQ) begin
          w_next = S_IDLE;
        end
      end
      S_GRANT: begin
        if (intEOP || (r_sawDack && !assertDACK)) begin
          w_next    = S_IDLE;
          w_release = 1'b1;
        end else if (!HLDA && !assertDACK) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state          <= S_IDLE;
      r_reqQ           <= '0;
      r_lowestCh       <= CW'(NUM_CH - 1);
      r_grantedChannel <= '0;
      r_sawDack        <= 1'b0;
      r_clearSw        <= '0;
    end else begin
      r_state   <= w_next;
      r_reqQ    <= w_eff;
      r_clearSw <= '0;
      if (w_latch) begin
        r_grantedChannel <= w_winner;
      end
      if ((r_state == S_GRANT) && (w_next == S_GRANT)) begin
        r_sawDack <= r_sawDack | assertDACK;
      end else begin
        r_sawDack <= 1'b0;
      end
      if (w_release) begin
        if (rotatingPriority) begin
          r_lowestCh <= r_grantedChannel;
        end
        if (intEOP) begin
          r_clearSw[r_grantedChannel] <= 1'b1;
        end
      end
    end
  end

  assign requestPending = |r_reqQ;
  assign grantValid     = (r_state == S_GRANT);
  assign grantedChannel = r_grantedChannel;
  assign clearSwRequest = r_clearSw;

  // Combinational so the sequencer sees DACK in the cycle it raises the strobe.
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_dack
      assign DACK[i] = grantValid & assertDACK & (r_grantedChannel == CW'(i));
    end
  endgenerate

endmodule

`default_nettype wire
